// File: rtl/icache_pkg.sv
// Shared icache definitions: requester source encoding and default widths,
// common to the response router and the request arbiter.
package icache_pkg;

  typedef enum logic [1:0] {
    SRC_NONE     = 2'b00,
    SRC_UPSTREAM = 2'b01,
    SRC_SNOOP    = 2'b10,
    SRC_PREFETCH = 2'b11
  } icache_src_e;

  localparam int ICACHE_REQ_OPCODE_WIDTH_DEF   = 7;
  localparam int ICACHE_TAGREQ_TXNID_WIDTH_DEF = 4;
  localparam int ICACHE_RSP_DATA_WIDTH_DEF     = 64;
  localparam int RSP_FIFO_DEPTH_DEF            = 2;

endpackage

// File: rtl/icache_rsp_fifo.sv
// Small valid/ready FIFO with registered storage. Full is derived from the
// registered count only, so a pop never frees a slot for a same-cycle push.
module icache_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld_i,
  output logic             push_rdy_o,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             pop_vld_o,
  input  logic             pop_rdy_i,
  output logic [WIDTH-1:0] pop_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign push_rdy_o = (count_q != FULL_CNT);
  assign pop_vld_o  = (count_q != '0);
  assign push       = push_vld_i && push_rdy_o;
  assign pop        = pop_vld_o && pop_rdy_i;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/icache_rsp_router.sv
// Routes tag-pipeline responses to the upstream, snoop and prefetch channels
// through independent per-destination queues; invalid-source beats are dropped.
module icache_rsp_router
  import icache_pkg::*;
#(
  parameter int ICACHE_REQ_OPCODE_WIDTH   = ICACHE_REQ_OPCODE_WIDTH_DEF,
  parameter int ICACHE_TAGREQ_TXNID_WIDTH = ICACHE_TAGREQ_TXNID_WIDTH_DEF,
  parameter int ICACHE_RSP_DATA_WIDTH     = ICACHE_RSP_DATA_WIDTH_DEF,
  parameter int RSP_FIFO_DEPTH            = RSP_FIFO_DEPTH_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 tag_rsp_vld,
  output logic                                 tag_rsp_rdy,
  input  logic [1:0]                           tag_rsp_src,
  input  logic [ICACHE_REQ_OPCODE_WIDTH-1:0]   tag_rsp_opcode,
  input  logic [ICACHE_TAGREQ_TXNID_WIDTH-1:0] tag_rsp_txnid,
  input  logic [ICACHE_RSP_DATA_WIDTH-1:0]     tag_rsp_data,
  output logic                                 upstream_txrsp_vld,
  input  logic                                 upstream_txrsp_rdy,
  output logic [ICACHE_REQ_OPCODE_WIDTH-1:0]   upstream_txrsp_opcode,
  output logic [ICACHE_TAGREQ_TXNID_WIDTH-1:0] upstream_txrsp_txnid,
  output logic [ICACHE_RSP_DATA_WIDTH-1:0]     upstream_txrsp_data,
  output logic                                 downstream_txsnprsp_vld,
  input  logic                                 downstream_txsnprsp_rdy,
  output logic [ICACHE_REQ_OPCODE_WIDTH-1:0]   downstream_txsnprsp_opcode,
  output logic [ICACHE_TAGREQ_TXNID_WIDTH-1:0] downstream_txsnprsp_txnid,
  output logic                                 prefetch_rsp_vld,
  input  logic                                 prefetch_rsp_rdy,
  output logic [ICACHE_TAGREQ_TXNID_WIDTH-1:0] prefetch_rsp_txnid,
  output logic                                 rsp_src_err
);

  localparam int OPC = ICACHE_REQ_OPCODE_WIDTH;
  localparam int TXN = ICACHE_TAGREQ_TXNID_WIDTH;
  localparam int DAT = ICACHE_RSP_DATA_WIDTH;

  logic up_push, sn_push, pf_push;
  logic up_free, sn_free, pf_free;
  logic src_err_q, src_err_d;

  assign up_push = tag_rsp_vld && (tag_rsp_src == SRC_UPSTREAM);
  assign sn_push = tag_rsp_vld && (tag_rsp_src == SRC_SNOOP);
  assign pf_push = tag_rsp_vld && (tag_rsp_src == SRC_PREFETCH);

  always_comb begin
    tag_rsp_rdy = 1'b1;
    case (tag_rsp_src)
      SRC_UPSTREAM: tag_rsp_rdy = up_free;
      SRC_SNOOP:    tag_rsp_rdy = sn_free;
      SRC_PREFETCH: tag_rsp_rdy = pf_free;
      default:      tag_rsp_rdy = 1'b1;
    endcase
  end

  // An invalid-source beat is always accepted, so valid alone marks the drop.
  assign src_err_d   = tag_rsp_vld && (tag_rsp_src == SRC_NONE);
  assign rsp_src_err = src_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) src_err_q <= 1'b0;
    else       src_err_q <= src_err_d;
  end

  icache_rsp_fifo #(.WIDTH(OPC + TXN + DAT), .DEPTH(RSP_FIFO_DEPTH)) u_up_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_vld_i (up_push),
    .push_rdy_o (up_free),
    .push_data_i({tag_rsp_opcode, tag_rsp_txnid, tag_rsp_data}),
    .pop_vld_o  (upstream_txrsp_vld),
    .pop_rdy_i  (upstream_txrsp_rdy),
    .pop_data_o ({upstream_txrsp_opcode, upstream_txrsp_txnid, upstream_txrsp_data})
  );

  icache_rsp_fifo #(.WIDTH(OPC + TXN), .DEPTH(RSP_FIFO_DEPTH)) u_snp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_vld_i (sn_push),
    .push_rdy_o (sn_free),
    .push_data_i({tag_rsp_opcode, tag_rsp_txnid}),
    .pop_vld_o  (downstream_txsnprsp_vld),
    .pop_rdy_i  (downstream_txsnprsp_rdy),
    .pop_data_o ({downstream_txsnprsp_opcode, downstream_txsnprsp_txnid})
  );

  icache_rsp_fifo #(.WIDTH(TXN), .DEPTH(RSP_FIFO_DEPTH)) u_pf_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_vld_i (pf_push),
    .push_rdy_o (pf_free),
    .push_data_i(tag_rsp_txnid),
    .pop_vld_o  (prefetch_rsp_vld),
    .pop_rdy_i  (prefetch_rsp_rdy),
    .pop_data_o (prefetch_rsp_txnid)
  );

endmodule

// File: tb/tb_icache_rsp_router.sv
// Directed and randomized checks of icache_rsp_router against queue-based
// per-destination reference behaviour.
module tb_icache_rsp_router;

  localparam int OPC   = 7;
  localparam int TXN   = 4;
  localparam int DAT   = 64;
  localparam int DEPTH = 2;
  localparam int DW    = OPC + TXN + DAT;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           tag_rsp_vld = 1'b0;
  logic           tag_rsp_rdy;
  logic [1:0]     tag_rsp_src = 2'b00;
  logic [OPC-1:0] tag_rsp_opcode = '0;
  logic [TXN-1:0] tag_rsp_txnid = '0;
  logic [DAT-1:0] tag_rsp_data = '0;
  logic           up_vld, up_rdy = 1'b0;
  logic [OPC-1:0] up_opc;
  logic [TXN-1:0] up_txn;
  logic [DAT-1:0] up_data;
  logic           sn_vld, sn_rdy = 1'b0;
  logic [OPC-1:0] sn_opc;
  logic [TXN-1:0] sn_txn;
  logic           pf_vld, pf_rdy = 1'b0;
  logic [TXN-1:0] pf_txn;
  logic           src_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  icache_rsp_router #(
    .ICACHE_REQ_OPCODE_WIDTH  (OPC),
    .ICACHE_TAGREQ_TXNID_WIDTH(TXN),
    .ICACHE_RSP_DATA_WIDTH    (DAT),
    .RSP_FIFO_DEPTH           (DEPTH)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .tag_rsp_vld               (tag_rsp_vld),
    .tag_rsp_rdy               (tag_rsp_rdy),
    .tag_rsp_src               (tag_rsp_src),
    .tag_rsp_opcode            (tag_rsp_opcode),
    .tag_rsp_txnid             (tag_rsp_txnid),
    .tag_rsp_data              (tag_rsp_data),
    .upstream_txrsp_vld        (up_vld),
    .upstream_txrsp_rdy        (up_rdy),
    .upstream_txrsp_opcode     (up_opc),
    .upstream_txrsp_txnid      (up_txn),
    .upstream_txrsp_data       (up_data),
    .downstream_txsnprsp_vld   (sn_vld),
    .downstream_txsnprsp_rdy   (sn_rdy),
    .downstream_txsnprsp_opcode(sn_opc),
    .downstream_txsnprsp_txnid (sn_txn),
    .prefetch_rsp_vld          (pf_vld),
    .prefetch_rsp_rdy          (pf_rdy),
    .prefetch_rsp_txnid        (pf_txn),
    .rsp_src_err               (src_err)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] src, input logic [TXN-1:0] txn, input logic [DAT-1:0] dat);
    tag_rsp_vld    = 1'b1;
    tag_rsp_src    = src;
    tag_rsp_txnid  = txn;
    tag_rsp_opcode = OPC'(txn) + 7'd10;
    tag_rsp_data   = dat;
  endtask

  task automatic idle();
    tag_rsp_vld = 1'b0;
    tag_rsp_src = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    up_rdy = 1'b0; sn_rdy = 1'b0; pf_rdy = 1'b0;
    idle();
    repeat (2) step();
    n_checks++;
    if ({up_vld, sn_vld, pf_vld, src_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: vld/err=%b required 0000", {up_vld, sn_vld, pf_vld, src_err});
    end
    reset = 1'b0;
    offer(2'b10, 4'd0, '0);
    #1;
    n_checks++;
    if (tag_rsp_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdy: tag_rsp_rdy=%b required 1", tag_rsp_rdy);
    end
    idle();
    step();
  endtask

  task automatic test_upstream_basic();
    up_rdy = 1'b1;
    offer(2'b01, 4'd3, 64'hDEAD_BEEF);
    #1;
    n_checks++;
    if (tag_rsp_rdy !== 1'b1 || up_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL up_accept: rdy=%b vld=%b required rdy=1 vld=0", tag_rsp_rdy, up_vld);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (up_vld !== 1'b1 || up_txn !== 4'd3 || up_data !== 64'hDEAD_BEEF || up_opc !== 7'd13) begin
      n_fail++;
      $display("FAIL up_latency1: vld=%b txn=%0d data=%h opc=%0d required 1/3/deadbeef/13",
               up_vld, up_txn, up_data, up_opc);
    end
    step();
    n_checks++;
    if (up_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL up_popped: vld=%b required 0", up_vld);
    end
  endtask

  task automatic test_snoop_backpressure();
    sn_rdy = 1'b0;
    up_rdy = 1'b1;
    offer(2'b10, 4'd1, '0);
    step();
    offer(2'b10, 4'd2, '0);
    step();
    offer(2'b10, 4'd3, '0);
    #1;
    n_checks++;
    if (tag_rsp_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL snp_full_rdy: tag_rsp_rdy=%b required 0", tag_rsp_rdy);
    end
    offer(2'b01, 4'd9, 64'h1234);
    #1;
    n_checks++;
    if (tag_rsp_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL up_not_blocked: tag_rsp_rdy=%b required 1", tag_rsp_rdy);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (up_vld !== 1'b1 || up_txn !== 4'd9 || sn_vld !== 1'b1 || sn_txn !== 4'd1) begin
      n_fail++;
      $display("FAIL independent_q: up_vld=%b up_txn=%0d sn_vld=%b sn_txn=%0d required 1/9/1/1",
               up_vld, up_txn, sn_vld, sn_txn);
    end
    step();
  endtask

  task automatic test_full_pop();
    // Snoop queue holds txnid 1,2 from the previous scenario.
    offer(2'b10, 4'd3, '0);
    sn_rdy = 1'b1;
    #1;
    n_checks++;
    if (tag_rsp_rdy !== 1'b0 || sn_txn !== 4'd1 || sn_opc !== 7'd11) begin
      n_fail++;
      $display("FAIL no_bypass: rdy=%b sn_txn=%0d sn_opc=%0d required 0/1/11", tag_rsp_rdy, sn_txn, sn_opc);
    end
    step();
    sn_rdy = 1'b0;
    #1;
    n_checks++;
    if (tag_rsp_rdy !== 1'b1 || sn_vld !== 1'b1 || sn_txn !== 4'd2) begin
      n_fail++;
      $display("FAIL after_pop: rdy=%b sn_vld=%b sn_txn=%0d required 1/1/2", tag_rsp_rdy, sn_vld, sn_txn);
    end
    step();
    idle();
    sn_rdy = 1'b1;
    #1;
    n_checks++;
    if (sn_txn !== 4'd2) begin
      n_fail++;
      $display("FAIL snp_order2: sn_txn=%0d required 2", sn_txn);
    end
    step();
    n_checks++;
    if (sn_vld !== 1'b1 || sn_txn !== 4'd3) begin
      n_fail++;
      $display("FAIL snp_order3: sn_vld=%b sn_txn=%0d required 1/3", sn_vld, sn_txn);
    end
    step();
    n_checks++;
    if (sn_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL snp_drained: sn_vld=%b required 0", sn_vld);
    end
  endtask

  task automatic test_invalid_src();
    offer(2'b00, 4'd7, 64'hFFFF);
    #1;
    n_checks++;
    if (tag_rsp_rdy !== 1'b1 || src_err !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_rdy: rdy=%b err=%b required 1/0", tag_rsp_rdy, src_err);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (src_err !== 1'b1 || {up_vld, sn_vld, pf_vld} !== 3'b000) begin
      n_fail++;
      $display("FAIL inv_pulse: err=%b vld=%b required 1/000", src_err, {up_vld, sn_vld, pf_vld});
    end
    step();
    n_checks++;
    if (src_err !== 1'b0 || {up_vld, sn_vld, pf_vld} !== 3'b000) begin
      n_fail++;
      $display("FAIL inv_end: err=%b vld=%b required 0/000", src_err, {up_vld, sn_vld, pf_vld});
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] q_up[$];
    logic [DW-1:0] q_sn[$];
    logic [DW-1:0] q_pf[$];
    logic          err_exp = 1'b0;
    logic          exp_rdy, pop_up, pop_sn, pop_pf;
    int            accepted = 0;
    int            cycles = 0;
    int            drain = 0;
    while (drain < 2 * DEPTH + 3 && cycles < 3000) begin
      if (accepted < 100) begin
        tag_rsp_vld    = ($urandom_range(0, 9) < 7);
        tag_rsp_src    = ($urandom_range(0, 11) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        tag_rsp_opcode = OPC'($urandom);
        tag_rsp_txnid  = TXN'($urandom);
        tag_rsp_data   = {$urandom, $urandom};
        up_rdy = 1'($urandom_range(0, 1));
        sn_rdy = 1'($urandom_range(0, 1));
        pf_rdy = 1'($urandom_range(0, 1));
      end else begin
        idle();
        up_rdy = 1'b1; sn_rdy = 1'b1; pf_rdy = 1'b1;
        drain++;
      end
      #1;
      case (tag_rsp_src)
        2'b01:   exp_rdy = (q_up.size() < DEPTH);
        2'b10:   exp_rdy = (q_sn.size() < DEPTH);
        2'b11:   exp_rdy = (q_pf.size() < DEPTH);
        default: exp_rdy = 1'b1;
      endcase
      n_checks++;
      if (tag_rsp_rdy !== exp_rdy || src_err !== err_exp) begin
        n_fail++;
        $display("FAIL rnd_rdy_err cyc%0d: rdy=%b err=%b required %b/%b", cycles, tag_rsp_rdy, src_err, exp_rdy, err_exp);
      end
      n_checks++;
      if (up_vld !== (q_up.size() != 0) ||
          (q_up.size() != 0 && DW'({up_opc, up_txn, up_data}) !== q_up[0])) begin
        n_fail++;
        $display("FAIL rnd_up cyc%0d: vld=%b payload=%h required vld=%b", cycles, up_vld, {up_opc, up_txn, up_data}, q_up.size() != 0);
      end
      n_checks++;
      if (sn_vld !== (q_sn.size() != 0) ||
          (q_sn.size() != 0 && DW'({sn_opc, sn_txn}) !== q_sn[0])) begin
        n_fail++;
        $display("FAIL rnd_snp cyc%0d: vld=%b payload=%h required vld=%b", cycles, sn_vld, {sn_opc, sn_txn}, q_sn.size() != 0);
      end
      n_checks++;
      if (pf_vld !== (q_pf.size() != 0) || (q_pf.size() != 0 && DW'(pf_txn) !== q_pf[0])) begin
        n_fail++;
        $display("FAIL rnd_pf cyc%0d: vld=%b txn=%0d required vld=%b", cycles, pf_vld, pf_txn, q_pf.size() != 0);
      end
      pop_up = up_rdy && (q_up.size() != 0);
      pop_sn = sn_rdy && (q_sn.size() != 0);
      pop_pf = pf_rdy && (q_pf.size() != 0);
      err_exp = 1'b0;
      if (tag_rsp_vld && exp_rdy) begin
        case (tag_rsp_src)
          2'b01:   begin q_up.push_back(DW'({tag_rsp_opcode, tag_rsp_txnid, tag_rsp_data})); accepted++; end
          2'b10:   begin q_sn.push_back(DW'({tag_rsp_opcode, tag_rsp_txnid})); accepted++; end
          2'b11:   begin q_pf.push_back(DW'(tag_rsp_txnid)); accepted++; end
          default: err_exp = 1'b1;
        endcase
      end
      if (pop_up) void'(q_up.pop_front());
      if (pop_sn) void'(q_sn.pop_front());
      if (pop_pf) void'(q_pf.pop_front());
      step();
      cycles++;
    end
    n_checks++;
    if (accepted < 100 || q_up.size() + q_sn.size() + q_pf.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_complete: accepted=%0d left=%0d required 100/0", accepted, q_up.size() + q_sn.size() + q_pf.size());
    end
  endtask

  task automatic test_reset_midflight();
    up_rdy = 1'b0; sn_rdy = 1'b0; pf_rdy = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      for (int k = 0; k < 2; k++) begin
        offer(2'(s), 4'(k + 4), '0);
        step();
      end
    end
    idle();
    #1;
    n_checks++;
    if ({up_vld, sn_vld, pf_vld} !== 3'b111) begin
      n_fail++;
      $display("FAIL prefill: vld=%b required 111", {up_vld, sn_vld, pf_vld});
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({up_vld, sn_vld, pf_vld, src_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: vld/err=%b required 0000", {up_vld, sn_vld, pf_vld, src_err});
    end
    step();
    step();
    reset = 1'b0;
    pf_rdy = 1'b1;
    offer(2'b11, 4'd5, '0);
    #1;
    n_checks++;
    if (tag_rsp_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_rdy: rdy=%b required 1", tag_rsp_rdy);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (pf_vld !== 1'b1 || pf_txn !== 4'd5 || up_vld !== 1'b0 || sn_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_route: pf_vld=%b pf_txn=%0d up=%b sn=%b required 1/5/0/0", pf_vld, pf_txn, up_vld, sn_vld);
    end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_upstream_basic();
    test_snoop_backpressure();
    test_full_pop();
    test_invalid_src();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_rsp_router.md
ICACHE_RSP_ROUTER -- requirements
Module: icache_rsp_router

Interface
REQ-001 SHALL have parameter ICACHE_REQ_OPCODE_WIDTH, default 7, the response opcode width.
REQ-002 SHALL have parameter ICACHE_TAGREQ_TXNID_WIDTH, default 4, the transaction ID width.
REQ-003 SHALL have parameter ICACHE_RSP_DATA_WIDTH, default 64, the response data width.
REQ-004 SHALL have parameter RSP_FIFO_DEPTH, default 2, the entries per destination queue (power of 2, ≥2).
REQ-005 SHALL have port clk, input, 1, the clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-007 SHALL have port tag_rsp_vld, input, 1, a pipeline response valid.
REQ-008 SHALL have port tag_rsp_rdy, output, 1, the router accept.
REQ-009 SHALL have port tag_rsp_src, input, 2, the originating requester: 01 upstream, 10 snoop, 11 prefetch, 00 invalid.
REQ-010 SHALL have port tag_rsp_opcode, input, ICACHE_REQ_OPCODE_WIDTH, the response opcode.
REQ-011 SHALL have port tag_rsp_txnid, input, ICACHE_TAGREQ_TXNID_WIDTH, the echoed request txnid.
REQ-012 SHALL have port tag_rsp_data, input, ICACHE_RSP_DATA_WIDTH, the instruction data (upstream only).
REQ-013 SHALL have ports upstream_txrsp_vld/rdy/opcode/txnid/data, out/in/out/out/out, 1/1/OPC/TXN/DATA, the core response channel.
REQ-014 SHALL have ports downstream_txsnprsp_vld/rdy/opcode/txnid, out/in/out/out, 1/1/OPC/TXN, the snoop response channel.
REQ-015 SHALL have ports prefetch_rsp_vld/rdy/txnid, out/in/out, 1/1/TXN, the prefetch completion channel.
REQ-016 SHALL have port rsp_src_err, output, 1, a one-cycle pulse when an invalid-source beat is dropped.

Function
REQ-017 SHALL accept a beat when tag_rsp_vld && tag_rsp_rdy are both 1 in the same cycle.
REQ-018 SHALL drive tag_rsp_rdy combinationally as: src=00 → 1; otherwise → the selected destination queue is not full.
REQ-019 SHALL compute full from the registered count only; a same-cycle pop SHALL NOT free a slot for a push (no bypass).
REQ-020 SHALL push an accepted beat with src 01/10/11 into the upstream, snoop or prefetch queue respectively, storing only the fields that destination uses.
REQ-021 SHALL discard an accepted src=00 beat and assert rsp_src_err for exactly the next cycle.
REQ-022 SHALL make a pushed beat visible at the destination output no earlier than the cycle after acceptance (registered queue, minimum latency 1).
REQ-023 SHALL drive each destination's vld = its queue count ≠ 0, with payload taken from the queue head.
REQ-024 SHALL pop a queue when its vld && rdy are both 1; payload SHALL stay stable while vld=1 and rdy=0.
REQ-025 SHALL preserve FIFO order within each destination; the three queues SHALL be independent, so a stall on one channel SHALL NOT block the others.
REQ-026 SHALL, on a simultaneous push and pop to a non-full queue, leave the count unchanged and keep the data correct.
REQ-027 SHALL size per-queue count as $clog2(RSP_FIFO_DEPTH)+1 bits, with read/write pointers of $clog2(RSP_FIFO_DEPTH) bits that wrap modulo the depth.
REQ-028 SHALL never overflow or underflow a queue.

Reset
REQ-029 SHALL, while reset=1, clear all counts and pointers and force all vld outputs, rsp_src_err = 0.
REQ-030 SHALL let reset asserted mid-operation discard all queued beats; payload outputs SHALL be don't-care while vld=0, and storage SHALL NOT need clearing.
REQ-031 SHALL present tag_rsp_rdy = 1 in the first cycle after reset deasserts.

Structure
REQ-032 SHALL place the source encoding constants (SRC_NONE, SRC_UPSTREAM, SRC_SNOOP, SRC_PREFETCH) in the shared package icache_pkg, used by both this block and the request arbiter.
REQ-033 SHALL place the width parameter defaults in icache_pkg.
REQ-034 SHALL instantiate one sub-module, icache_rsp_fifo (parameterised width/depth, vld/rdy push and pop), three times.

Verification
REQ-035 SHALL cover this scenario: src=01, txnid=3, data=0xDEAD_BEEF accepted at cycle N with upstream_rdy=1 → upstream_txrsp_vld=1 at N+1 with txnid=3, data=0xDEADBEEF; popped at N+1.
REQ-036 SHALL cover this scenario: snoop rdy=0; two src=10 beats (txnid 1, 2) accepted, a third src=10 is offered → tag_rsp_rdy=0; a src=01 beat is then accepted the same cycle it is offered.
REQ-037 SHALL cover this scenario: queue full and sink rdy rises → one pop; tag_rsp_rdy=1 the next cycle (not the same cycle); order txnid 1 then 2.
REQ-038 SHALL cover this scenario: src=00 beat → rdy=1, no channel vld, rsp_src_err=1 for exactly one cycle.
REQ-039 SHALL cover this scenario: 100 random beats across sources with random sink rdy → per-source order and payload match the scoreboard, with no loss or duplication.
REQ-040 SHALL cover this scenario: reset asserted with 2 beats in each queue → all vld=0 at once; after release, a new beat routes normally.
